// File: rtl/sddt_axis_pkg.sv
// Shared AXI-Stream width defaults and helpers for the instruction/data FIFO
// read path.
package sddt_axis_pkg;

  localparam int AXIS_WIDE_W   = 512;
  localparam int AXIS_NARROW_W = 64;

  // Counter width for an n-way lane index, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_word_unpacker.sv
// Pops one wide word from an AXI-Stream FIFO and re-emits it as RATIO narrow
// beats, with TLAST on the final lane of every wide word.
module axis_word_unpacker
  import sddt_axis_pkg::*;
#(
  parameter int IN_WIDTH  = AXIS_WIDE_W,
  parameter int OUT_WIDTH = AXIS_NARROW_W,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  output logic [OUT_WIDTH-1:0] M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic                 M_AXIS_TLAST,
  output logic [CNT_WIDTH-1:0] WORD_COUNT,
  output logic                 BUSY
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int LANE_W = clog2_min1(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
    $error("axis_word_unpacker: OUT_WIDTH must divide IN_WIDTH exactly");
  end

  logic [IN_WIDTH-1:0]  hold_q,  hold_d;
  logic                 full_q,  full_d;
  logic [LANE_W-1:0]    lane_q,  lane_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic              m_hs;
  logic              last_hs;
  logic              s_rdy;
  logic              s_hs;
  logic [LANE_W-1:0] lane_idx;

  // Handshake decode. Accepting a new word in the same cycle as the final lane
  // handshake is what removes the bubble between consecutive words.
  always_comb begin
    m_hs    = full_q && M_AXIS_TREADY;
    last_hs = m_hs && (lane_q == LAST_LANE);
    s_rdy   = !rst && (!full_q || last_hs);
    s_hs    = S_AXIS_TVALID && s_rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      full_q  <= 1'b0;
      lane_q  <= '0;
      count_q <= '0;
    end else begin
      hold_q  <= hold_d;
      full_q  <= full_d;
      lane_q  <= lane_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    hold_d  = hold_q;
    full_d  = full_q;
    lane_d  = lane_q;
    count_d = count_q;
    if (last_hs) begin
      count_d = count_q + CNT_WIDTH'(1);
      full_d  = 1'b0;
      lane_d  = '0;
    end else if (m_hs) begin
      lane_d = lane_q + LANE_W'(1);
    end
    // A reload overrides the drain above so the register stays occupied.
    if (s_hs) begin
      hold_d = S_AXIS_TDATA;
      full_d = 1'b1;
      lane_d = '0;
    end
  end

  always_comb begin
    lane_idx      = LSB_FIRST ? lane_q : (LAST_LANE - lane_q);
    M_AXIS_TDATA  = hold_q[lane_idx * OUT_WIDTH +: OUT_WIDTH];
    M_AXIS_TVALID = full_q;
    M_AXIS_TLAST  = full_q && (lane_q == LAST_LANE);
    S_AXIS_TREADY = s_rdy;
    WORD_COUNT    = count_q;
    BUSY          = full_q;
  end

endmodule

// File: tb/tb_axis_word_unpacker.sv
// Directed bench for axis_word_unpacker: three instances (LSB-first, MSB-first,
// 4-bit counter) share one stimulus stream and are checked beat by beat.
module tb_axis_word_unpacker;

  localparam int IW = 512;
  localparam int OW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] s_tdata;
  logic          s_tvalid;
  logic          m_tready;

  logic          s_tready_a, m_tvalid_a, m_tlast_a, busy_a;
  logic [OW-1:0] m_tdata_a;
  logic [31:0]   wc_a;
  logic          s_tready_b, m_tvalid_b, m_tlast_b, busy_b;
  logic [OW-1:0] m_tdata_b;
  logic [31:0]   wc_b;
  logic          s_tready_c, m_tvalid_c, m_tlast_c, busy_c;
  logic [OW-1:0] m_tdata_c;
  logic [3:0]    wc_c;

  always #5 clk = ~clk;

  axis_word_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1'b1), .CNT_WIDTH(32)) dut_lsb (
    .clk(clk), .rst(rst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready_a),
    .M_AXIS_TDATA(m_tdata_a), .M_AXIS_TVALID(m_tvalid_a), .M_AXIS_TREADY(m_tready),
    .M_AXIS_TLAST(m_tlast_a), .WORD_COUNT(wc_a), .BUSY(busy_a)
  );

  axis_word_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1'b0), .CNT_WIDTH(32)) dut_msb (
    .clk(clk), .rst(rst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready_b),
    .M_AXIS_TDATA(m_tdata_b), .M_AXIS_TVALID(m_tvalid_b), .M_AXIS_TREADY(m_tready),
    .M_AXIS_TLAST(m_tlast_b), .WORD_COUNT(wc_b), .BUSY(busy_b)
  );

  axis_word_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1'b1), .CNT_WIDTH(4)) dut_cnt (
    .clk(clk), .rst(rst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready_c),
    .M_AXIS_TDATA(m_tdata_c), .M_AXIS_TVALID(m_tvalid_c), .M_AXIS_TREADY(m_tready),
    .M_AXIS_TLAST(m_tlast_c), .WORD_COUNT(wc_c), .BUSY(busy_c)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [IW-1:0] src[$];
  logic [OW-1:0] exp_d[$];
  logic [OW-1:0] exp_m[$];
  logic          exp_l[$];

  int            beats, lasts, first_beat_cyc, last_beat_cyc;
  logic [OW-1:0] first_msb, last_msb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic add_word(input logic [IW-1:0] w);
    src.push_back(w);
    for (int i = 0; i < IW / OW; i++) begin
      exp_d.push_back(w[i*OW +: OW]);
      exp_m.push_back(w[(IW/OW-1-i)*OW +: OW]);
      exp_l.push_back(i == IW / OW - 1);
    end
  endtask

  task automatic add_random_word();
    logic [IW-1:0] w;
    for (int j = 0; j < IW / 32; j++) w[j*32 +: 32] = $urandom();
    add_word(w);
  endtask

  // Called at posedge+1; drives sources/sink for one cycle per iteration.
  task automatic run(input int nbeats, input bit rnd, input int budget);
    int            cyc = 0;
    bit            stalled_prev = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    beats = 0; lasts = 0; first_beat_cyc = -1; last_beat_cyc = -1;
    while (beats < nbeats && cyc < budget) begin
      s_tvalid = (src.size() > 0);
      s_tdata  = (src.size() > 0) ? src[0] : '0;
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled_prev) begin
        chk("stall_data", 64'(m_tdata_a), 64'(prev_data));
        chk("stall_last", 64'(m_tlast_a), 64'(prev_last));
        chk("stall_valid", 64'(m_tvalid_a), 64'(1));
      end
      if (m_tvalid_a) chk("s_tready_pulse", 64'(s_tready_a), 64'(m_tready && m_tlast_a));
      if (m_tvalid_a && m_tready) begin
        chk("lane_data", 64'(m_tdata_a), (exp_d.size() > 0) ? 64'(exp_d[0]) : 64'bx);
        chk("msb_data", 64'(m_tdata_b), (exp_m.size() > 0) ? 64'(exp_m[0]) : 64'bx);
        chk("tlast", 64'(m_tlast_a), (exp_l.size() > 0) ? 64'(exp_l[0]) : 64'bx);
        if (exp_d.size() > 0) begin
          void'(exp_d.pop_front());
          void'(exp_m.pop_front());
          void'(exp_l.pop_front());
        end
        if (first_beat_cyc < 0) begin
          first_beat_cyc = cyc;
          first_msb      = m_tdata_b;
        end
        last_beat_cyc = cyc;
        last_msb      = m_tdata_b;
        beats++;
        if (m_tlast_a) lasts++;
      end
      stalled_prev = m_tvalid_a && !m_tready;
      prev_data    = m_tdata_a;
      prev_last    = m_tlast_a;
      if (s_tvalid && s_tready_a) void'(src.pop_front());
      cyc++;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    chk("beat_budget", 64'(beats), 64'(nbeats));
  endtask

  initial begin
    logic [IW-1:0] w;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_tvalid", 64'(m_tvalid_a), 64'(0));
    chk("rst_tlast", 64'(m_tlast_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_s_tready", 64'(s_tready_a), 64'(0));
    chk("rst_count", 64'(wc_a), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_s_tready", 64'(s_tready_a), 64'(1));
    chk("idle_tvalid", 64'(m_tvalid_a), 64'(0));

    // Single word with lane i = 0x1111_0000_0000_0000*i + i
    for (int i = 0; i < 8; i++) w[i*OW +: OW] = 64'h1111_0000_0000_0000 * 64'(i) + 64'(i);
    add_word(w);
    run(8, 1'b0, 40);
    chk("t1_latency", 64'(first_beat_cyc), 64'(1));
    chk("t1_span", 64'(last_beat_cyc - first_beat_cyc), 64'(7));
    chk("t1_lasts", 64'(lasts), 64'(1));
    chk("t1_count", 64'(wc_a), 64'(1));
    chk("t1_busy", 64'(busy_a), 64'(0));

    // Three words back to back
    repeat (3) add_random_word();
    run(24, 1'b0, 60);
    chk("t2_span_no_bubble", 64'(last_beat_cyc - first_beat_cyc), 64'(23));
    chk("t2_lasts", 64'(lasts), 64'(3));
    chk("t2_count", 64'(wc_a), 64'(4));

    // Random downstream back-pressure
    repeat (4) add_random_word();
    run(32, 1'b1, 400);
    chk("t3_lasts", 64'(lasts), 64'(4));
    chk("t3_count", 64'(wc_a), 64'(8));

    // MSB-first ordering
    for (int i = 0; i < 8; i++) w[i*OW +: OW] = 64'(i);
    w[0 +: OW]    = 64'h0000_0000_0000_00A0;
    w[7*OW +: OW] = 64'hDEAD_BEEF_0000_0007;
    add_word(w);
    run(8, 1'b0, 40);
    chk("t4_msb_first", 64'(first_msb), 64'hDEAD_BEEF_0000_0007);
    chk("t4_msb_last_is_lane0", 64'(last_msb), 64'h0000_0000_0000_00A0);
    chk("t4_count_msb", 64'(wc_b), 64'(9));
    chk("t4_count_cnt4", 64'(wc_c), 64'(9));

    // Reset after the third beat of a word
    add_random_word();
    run(3, 1'b0, 40);
    chk("t5_mid_valid", 64'(m_tvalid_a), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_tvalid", 64'(m_tvalid_a), 64'(0));
    chk("t5_async_tlast", 64'(m_tlast_a), 64'(0));
    chk("t5_async_s_tready", 64'(s_tready_a), 64'(0));
    exp_d.delete();
    exp_m.delete();
    exp_l.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_count", 64'(wc_a), 64'(0));
    chk("t5_busy", 64'(busy_a), 64'(0));
    chk("t5_s_tready", 64'(s_tready_a), 64'(1));
    add_random_word();
    run(8, 1'b0, 40);
    chk("t5_restart_count", 64'(wc_a), 64'(1));

    // 4-bit counter wraps after the 16th word
    repeat (14) add_random_word();
    run(112, 1'b0, 300);
    chk("t6_count15", 64'(wc_c), 64'(15));
    add_random_word();
    run(8, 1'b0, 40);
    chk("t6_count_wrap", 64'(wc_c), 64'(0));
    chk("t6_count_wide", 64'(wc_a), 64'(16));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
